// File: rtl/lcd_pkg.sv
// Shared constants, state types and default 50 MHz timing for the HD44780 controller.
// Build option: define LCD_CURSOR_EN to turn on the cursor and blink in the display-control byte.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h28;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_DISP_CUR = 8'h0F;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

`ifdef LCD_CURSOR_EN
  localparam logic [7:0] CMD_DISP_CTRL = CMD_DISP_CUR;
`else
  localparam logic [7:0] CMD_DISP_CTRL = CMD_DISP_ON;
`endif

  // Init nibbles travel as the upper half of a byte sent in single-nibble mode
  localparam logic [7:0] INIT_NIB_3 = 8'h30;
  localparam logic [7:0] INIT_NIB_2 = 8'h20;

  localparam logic [3:0] STEP_REFRESH = 4'd8;

  localparam int DEF_T_PWRUP  = 750000;
  localparam int DEF_T_INIT1  = 205000;
  localparam int DEF_T_INIT2  = 5000;
  localparam int DEF_T_CMD    = 2000;
  localparam int DEF_T_CLEAR  = 82000;
  localparam int DEF_T_SETUP  = 2;
  localparam int DEF_T_EPULSE = 12;
  localparam int DEF_T_NIBGAP = 50;

  typedef enum logic [1:0] {ST_PWRUP, ST_BUSY, ST_WAIT} ctrl_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_PULSE, TX_GAP} tx_state_e;

endpackage

// File: rtl/lcd_nibble_tx.sv
// Sends one byte as two enable strobes (upper then lower nibble), or only the upper
// nibble in single mode; done is high in the cycle whose closing edge drops the last strobe.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int T_SETUP  = DEF_T_SETUP,
  parameter int T_EPULSE = DEF_T_EPULSE,
  parameter int T_NIBGAP = DEF_T_NIBGAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       rs_in,
  input  logic       single_in,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [3:0] lcd_d
);

  localparam logic [15:0] SETUP_LAST  = 16'(T_SETUP - 1);
  localparam logic [15:0] PULSE_LAST  = 16'(T_EPULSE - 1);
  localparam logic [15:0] NIBGAP_LAST = 16'(T_NIBGAP - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        single_q, single_d;
  logic        lower_q, lower_d;
  logic        rs_q, rs_d;
  logic        e_q, e_d;
  logic [3:0]  d_q, d_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      byte_q   <= '0;
      single_q <= 1'b0;
      lower_q  <= 1'b0;
      rs_q     <= 1'b0;
      e_q      <= 1'b0;
      d_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      single_q <= single_d;
      lower_q  <= lower_d;
      rs_q     <= rs_d;
      e_q      <= e_d;
      d_q      <= d_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    single_d = single_q;
    lower_d  = lower_q;
    rs_d     = rs_q;
    e_d      = e_q;
    d_d      = d_q;
    case (state_q)
      TX_IDLE: if (start) begin
        // Byte and rs are captured here so later buffer changes cannot disturb this transfer
        byte_d   = byte_in;
        rs_d     = rs_in;
        single_d = single_in;
        lower_d  = 1'b0;
        d_d      = byte_in[7:4];
        cnt_d    = '0;
        state_d  = TX_SETUP;
      end
      TX_SETUP: if (cnt_q == SETUP_LAST) begin
        e_d     = 1'b1;
        cnt_d   = '0;
        state_d = TX_PULSE;
      end else cnt_d = cnt_q + 16'd1;
      TX_PULSE: if (cnt_q == PULSE_LAST) begin
        e_d     = 1'b0;
        cnt_d   = '0;
        state_d = (single_q || lower_q) ? TX_IDLE : TX_GAP;
      end else cnt_d = cnt_q + 16'd1;
      TX_GAP: if (cnt_q == NIBGAP_LAST) begin
        d_d     = byte_q[3:0];
        lower_d = 1'b1;
        cnt_d   = '0;
        state_d = TX_SETUP;
      end else cnt_d = cnt_q + 16'd1;
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    done   = (state_q == TX_PULSE) && (cnt_q == PULSE_LAST) && (single_q || lower_q);
    lcd_rs = rs_q;
    lcd_e  = e_q;
    lcd_d  = d_q;
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 4-bit controller for a 2x16 panel: power-on init, then endless refresh from a 32-byte buffer.
// Build option: LCD_CURSOR_EN selects the cursor/blink display-control byte.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP  = DEF_T_PWRUP,
  parameter int T_INIT1  = DEF_T_INIT1,
  parameter int T_INIT2  = DEF_T_INIT2,
  parameter int T_CMD    = DEF_T_CMD,
  parameter int T_CLEAR  = DEF_T_CLEAR,
  parameter int T_SETUP  = DEF_T_SETUP,
  parameter int T_EPULSE = DEF_T_EPULSE,
  parameter int T_NIBGAP = DEF_T_NIBGAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_bus,
  output logic [4:0] mem_addr,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_d
);

  localparam logic [31:0] PWRUP_LAST = 32'(T_PWRUP - 1);

  ctrl_state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] wait_len_q, wait_len_d;
  logic [3:0]  step_q, step_d;
  logic [4:0]  addr_q, addr_d;
  logic        cmd_next_q, cmd_next_d;

  logic        start, tx_done, tx_rs, tx_single;
  logic [7:0]  tx_byte;
  logic [31:0] item_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_PWRUP;
      cnt_q      <= '0;
      wait_len_q <= '0;
      step_q     <= '0;
      addr_q     <= '0;
      cmd_next_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_len_q <= wait_len_d;
      step_q     <= step_d;
      addr_q     <= addr_d;
      cmd_next_q <= cmd_next_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_len_d = wait_len_q;
    step_d     = step_q;
    addr_d     = addr_q;
    cmd_next_d = cmd_next_q;
    case (state_q)
      ST_PWRUP, ST_WAIT: cnt_d = cnt_q + 32'd1;
      ST_BUSY: if (tx_done) begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      default: state_d = ST_PWRUP;
    endcase
    // Advancing the index as a character starts leaves a full byte time for the buffer read
    if (start) begin
      state_d    = ST_BUSY;
      cnt_d      = '0;
      wait_len_d = item_wait;
      if (step_q != STEP_REFRESH) step_d = step_q + 4'd1;
      else if (cmd_next_q) cmd_next_d = 1'b0;
      else begin
        addr_d     = addr_q + 5'd1;
        cmd_next_d = (addr_q[3:0] == 4'hF);
      end
    end
  end

  always_comb begin
    start = 1'b0;
    if (state_q == ST_PWRUP) start = (cnt_q == PWRUP_LAST);
    else if (state_q == ST_WAIT) start = (cnt_q == wait_len_q - 32'd1);
    tx_byte   = CMD_LINE1;
    tx_rs     = 1'b0;
    tx_single = 1'b0;
    item_wait = 32'(T_CMD);
    case (step_q)
      4'd0: begin tx_byte = INIT_NIB_3; tx_single = 1'b1; item_wait = 32'(T_INIT1); end
      4'd1: begin tx_byte = INIT_NIB_3; tx_single = 1'b1; item_wait = 32'(T_INIT2); end
      4'd2: begin tx_byte = INIT_NIB_3; tx_single = 1'b1; end
      4'd3: begin tx_byte = INIT_NIB_2; tx_single = 1'b1; end
      4'd4: tx_byte = CMD_FUNC_SET;
      4'd5: tx_byte = CMD_ENTRY;
      4'd6: tx_byte = CMD_DISP_CTRL;
      4'd7: begin tx_byte = CMD_CLEAR; item_wait = 32'(T_CMD + T_CLEAR); end
      default: begin
        if (cmd_next_q) tx_byte = addr_q[4] ? CMD_LINE2 : CMD_LINE1;
        else begin
          tx_byte = mem_bus;
          tx_rs   = 1'b1;
        end
      end
    endcase
  end

  lcd_nibble_tx #(
    .T_SETUP  (T_SETUP),
    .T_EPULSE (T_EPULSE),
    .T_NIBGAP (T_NIBGAP)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byte_in   (tx_byte),
    .rs_in     (tx_rs),
    .single_in (tx_single),
    .done      (tx_done),
    .lcd_rs    (lcd_rs),
    .lcd_e     (lcd_e),
    .lcd_d     (lcd_d)
  );

  assign mem_addr = addr_q;
  assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl: captures every enable strobe and checks values and spacing.
module tb_lcd_ctrl;

  localparam int T_PWRUP  = 20;
  localparam int T_INIT1  = 10;
  localparam int T_INIT2  = 5;
  localparam int T_CMD    = 4;
  localparam int T_CLEAR  = 8;
  localparam int T_SETUP  = 2;
  localparam int T_EPULSE = 3;
  localparam int T_NIBGAP = 3;

`ifdef LCD_CURSOR_EN
  localparam logic [7:0] DC = 8'h0F;
`else
  localparam logic [7:0] DC = 8'h0C;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_bus;
  logic [4:0] mem_addr;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [3:0] lcd_d;
  logic [7:0] mem [32];

  assign mem_bus = mem[mem_addr];
  always #5 clk = ~clk;

  lcd_ctrl #(
    .T_PWRUP (T_PWRUP), .T_INIT1 (T_INIT1), .T_INIT2 (T_INIT2), .T_CMD (T_CMD),
    .T_CLEAR (T_CLEAR), .T_SETUP (T_SETUP), .T_EPULSE (T_EPULSE), .T_NIBGAP (T_NIBGAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_bus  (mem_bus),
    .mem_addr (mem_addr),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_d    (lcd_d)
  );

  typedef struct {
    logic       rs;
    logic [3:0] d;
    int         rise;
    int         fall;
  } nib_t;

  nib_t       nq[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         last_fall = 0;
  int         rise_cyc = 0;
  bit         rw_err = 1'b0;
  bit         stab_err = 1'b0;
  bit         prev_e = 1'b0;
  logic       lat_rs = 1'b0;
  logic [3:0] lat_d = 4'h0;

  always @(posedge clk) cyc++;

  // Strobe monitor: records each pulse and flags bus movement while lcd_e is high or just fell
  always @(negedge clk) begin
    if (lcd_rw !== 1'b0) rw_err = 1'b1;
    if (rst) prev_e = 1'b0;
    else begin
      if (lcd_e && !prev_e) begin
        rise_cyc = cyc;
        lat_rs   = lcd_rs;
        lat_d    = lcd_d;
      end
      if ((lcd_e || prev_e) && (lcd_rs !== lat_rs || lcd_d !== lat_d)) stab_err = 1'b1;
      if (!lcd_e && prev_e) nq.push_back('{lcd_rs, lcd_d, rise_cyc, cyc});
      prev_e = lcd_e;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic get_nib(output nib_t n);
    int waited = 0;
    while (nq.size() == 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (nq.size() == 0) begin
      check_val("nibble_timeout", 32'd1, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
    n = nq.pop_front();
  endtask

  task automatic run_init(input int t0);
    logic [3:0] exp_nib [12];
    int         exp_gap [12];
    nib_t       n;
    exp_nib = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, DC[7:4], DC[3:0], 4'h0, 4'h1};
    exp_gap = '{0, T_INIT1, T_INIT2, T_CMD, T_CMD, T_NIBGAP, T_CMD, T_NIBGAP, T_CMD,
                T_NIBGAP, T_CMD, T_NIBGAP};
    for (int k = 0; k < 12; k++) begin
      get_nib(n);
      $display("init nibble %0d: rs=%0b d=0x%0h rise=%0d", k, n.rs, n.d, n.rise - t0);
      check_val($sformatf("init_nib%0d", k), {27'd0, n.rs, n.d}, {28'd0, exp_nib[k]});
      if (k == 0) begin
        check_val("pwrup_delay", n.rise - t0, T_PWRUP + T_SETUP);
        check_val("epulse_width", n.fall - n.rise, T_EPULSE);
      end else begin
        check_val($sformatf("init_gap%0d", k), n.rise - last_fall - T_SETUP, exp_gap[k]);
      end
      last_fall = n.fall;
    end
  endtask

  task automatic run_frame(input int fr, input int first_gap);
    nib_t       hi, lo;
    logic [7:0] exp_b;
    logic       exp_rs;
    int         idx;
    for (int j = 0; j < 34; j++) begin
      idx = -1;
      if (j == 0) begin
        exp_b = 8'h80; exp_rs = 1'b0;
      end else if (j == 17) begin
        exp_b = 8'hC0; exp_rs = 1'b0;
      end else begin
        idx    = (j < 17) ? j - 1 : j - 2;
        exp_b  = (fr == 2 && idx == 5) ? 8'h7A : 8'h41 + 8'(idx);
        exp_rs = 1'b1;
      end
      get_nib(hi);
      get_nib(lo);
      $display("frame %0d byte %0d: rs=%0b data=0x%0h%0h", fr, j, hi.rs, hi.d, lo.d);
      check_val($sformatf("frame%0d_byte%0d", fr, j), {22'd0, hi.rs, lo.rs, hi.d, lo.d},
                {22'd0, exp_rs, exp_rs, exp_b});
      check_val($sformatf("frame%0d_gap%0d", fr, j), hi.rise - last_fall - T_SETUP,
                (j == 0) ? first_gap : T_CMD);
      check_val($sformatf("frame%0d_nibgap%0d", fr, j), lo.rise - hi.fall - T_SETUP, T_NIBGAP);
      last_fall = lo.fall;
      if (fr == 1 && idx == 5) mem[5] = 8'h7A;
    end
  endtask

  initial begin
    int t0;
    int w;
    for (int i = 0; i < 32; i++) mem[i] = 8'h41 + 8'(i);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_lcd_e", lcd_e, 0);
    check_val("rst_lcd_rs", lcd_rs, 0);
    check_val("rst_lcd_rw", lcd_rw, 0);
    check_val("rst_lcd_d", lcd_d, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    t0 = cyc;
    $display("reset released at cycle %0d", t0);

    run_init(t0);
    run_frame(1, T_CMD + T_CLEAR);
    run_frame(2, T_CMD);

    // Reset in the middle of a character strobe
    w = 0;
    while (!(lcd_e === 1'b1 && lcd_rs === 1'b1 && mem_addr > 5'd3) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check_val("reach_mid_refresh", lcd_e, 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_lcd_e", lcd_e, 0);
    check_val("midrst_mem_addr", mem_addr, 0);
    check_val("midrst_lcd_rs", lcd_rs, 0);
    check_val("midrst_lcd_d", lcd_d, 0);
    @(negedge clk);
    rst = 1'b0;
    nq.delete();
    t0 = cyc;
    $display("reset released again at cycle %0d", t0);
    run_init(t0);

    check_val("lcd_rw_always_zero", rw_err, 0);
    check_val("bus_stable_around_e", stab_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
